// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit feeding {inst, inst_addr} to decode.
// Holds the PC and issues in-order reads to instruction memory. Returned words are
// buffered in a small FIFO. A redirect flushes the FIFO and drops responses that are
// still in flight. A NOP is presented whenever no fetched instruction is available.
//  clk, rst_n                      clock, asynchronous active-low reset
//  imem_req_o/addr_o/gnt_i         request handshake, issue = req && gnt
//  imem_rvalid_i/rdata_i           in-order read responses
//  jump_i/jump_addr_i              redirect from execute (highest priority)
//  stall_i                         downstream not ready, blocks pop only
//  inst_o/inst_addr_o/inst_valid_o instruction output to decode
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int PC_STEP = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  input  logic        stall_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);
  localparam logic [31:0] NOP = 32'h0000_0007;
  typedef enum logic [1:0] {RESET, RUN, DRAIN} state_t;
  state_t state;
  logic [31:0] pc;
  logic [CW-1:0] outst, discard, fifo_count, outst_d, discard_d, fifo_count_d;
  logic [AW-1:0] rd_ptr, wr_ptr, aq_rd, aq_wr;
  logic [31:0] fifo_data [FIFO_DEPTH];
  logic [31:0] fifo_addr [FIFO_DEPTH];
  logic [31:0] aq [FIFO_DEPTH];
  logic issue, resp, keep, drop, pop;
  // DRAIN is held exactly while discard is non-zero, so it selects which responses are stale.
  // Credit counts stale requests as outstanding, which is what keeps the FIFO from overflowing.
  always_comb begin
    imem_req_o = rst_n && !jump_i && (outst + fifo_count) < DEPTH_C && outst < MAX_C;
    imem_addr_o = pc;
    issue = imem_req_o && imem_gnt_i;
    resp = imem_rvalid_i && outst != '0;
    drop = resp && state == DRAIN;
    keep = resp && state != DRAIN && !jump_i;
    inst_valid_o = fifo_count != '0 && !jump_i;
    pop = inst_valid_o && !stall_i;
    inst_o = inst_valid_o ? fifo_data[rd_ptr] : NOP;
    inst_addr_o = inst_valid_o ? fifo_addr[rd_ptr] : 32'h0;
    outst_d = outst + CW'(issue) - CW'(resp);
    discard_d = jump_i ? outst - CW'(resp) : discard - CW'(drop);
    fifo_count_d = jump_i ? '0 : fifo_count + CW'(keep) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET;
      pc <= RESET_PC;
      outst <= '0;
      discard <= '0;
      fifo_count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      aq_rd <= '0;
      aq_wr <= '0;
    end else begin
      state <= discard_d != '0 ? DRAIN : RUN;
      pc <= jump_i ? jump_addr_i : issue ? pc + 32'(PC_STEP) : pc;
      outst <= outst_d;
      discard <= discard_d;
      fifo_count <= fifo_count_d;
      rd_ptr <= jump_i ? '0 : rd_ptr + AW'(pop);
      wr_ptr <= jump_i ? '0 : wr_ptr + AW'(keep);
      aq_rd <= jump_i ? '0 : aq_rd + AW'(keep);
      aq_wr <= jump_i ? '0 : aq_wr + AW'(issue);
    end
  end
  always_ff @(posedge clk) begin
    if (keep) begin
      fifo_data[wr_ptr] <= imem_rdata_i;
      fifo_addr[wr_ptr] <= aq[aq_rd];
    end
    if (issue) aq[aq_wr] <= pc;
  end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed bench for ifu_fetch with a 1-cycle in-order memory model.
module tb_ifu_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic imem_req_o, imem_gnt_i, imem_rvalid_i, jump_i, stall_i, inst_valid_o;
  logic [31:0] imem_addr_o, imem_rdata_i, jump_addr_i, inst_o, inst_addr_o;
  int tests = 0;
  int fails = 0;
  logic [31:0] rq [$];
  bit hold;
  logic [31:0] pop_a [$];
  logic [31:0] pop_i [$];
  logic s_req, s_iv;
  logic [31:0] s_addr, s_ia, s_ii;

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .jump_i(jump_i), .jump_addr_i(jump_addr_i), .stall_i(stall_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    imem_rvalid_i = !hold && rq.size() > 0;
    imem_rdata_i = imem_rvalid_i ? ~rq[0] : 32'h0;
    #1;
    s_req = imem_req_o;
    s_addr = imem_addr_o;
    s_iv = inst_valid_o;
    s_ia = inst_addr_o;
    s_ii = inst_o;
    if (s_iv && !stall_i) begin
      pop_a.push_back(s_ia);
      pop_i.push_back(s_ii);
    end
    @(posedge clk);
    if (imem_rvalid_i) void'(rq.pop_front());
    if (s_req && imem_gnt_i) rq.push_back(s_addr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    jump_i = 1'b0;
    jump_addr_i = 32'h0;
    stall_i = 1'b0;
    imem_gnt_i = 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = 32'h0;
    hold = 1'b0;
    rq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pop_a.delete();
    pop_i.delete();
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    tests++; if (imem_req_o !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem_req_o); end
    tests++; if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", inst_valid_o); end
    tests++; if (inst_o !== 32'h7) begin fails++; $display("FAIL reset_nop: got %h want 00000007", inst_o); end
    tests++; if (inst_addr_o !== 32'h0) begin fails++; $display("FAIL reset_iaddr: got %h want 0", inst_addr_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    int first;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) begin
        tests++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin fails++; $display("FAIL stream_first_req: got req=%b addr=%h want 1/0", s_req, s_addr); end
      end
      if (k == 2) begin
        tests++; if (s_addr !== 32'h4) begin fails++; $display("FAIL stream_second_addr: got %h want 4", s_addr); end
      end
      if (s_iv && first == 0) first = k;
    end
    tests++; if (first != 3) begin fails++; $display("FAIL stream_latency: first valid at step %0d want 3", first); end
    tests++; if (pop_a.size() != 12) begin fails++; $display("FAIL stream_count: got %0d want 12", pop_a.size()); end
    for (int i = 0; i < 12; i++) begin
      tests++; if (pop_a.size() <= i || pop_a[i] !== 32'(i * 4) || pop_i[i] !== ~32'(i * 4)) begin fails++; $display("FAIL stream_word%0d: got addr=%h inst=%h want %h/%h", i, (pop_a.size() > i) ? pop_a[i] : 32'hx, (pop_i.size() > i) ? pop_i[i] : 32'hx, 32'(i * 4), ~32'(i * 4)); end
    end
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      tests++; if (s_iv !== 1'b1 || s_ia !== 32'd48 || s_ii !== ~32'd48) begin fails++; $display("FAIL stall_hold%0d: got v=%b addr=%h inst=%h want 1/30/%h", k, s_iv, s_ia, s_ii, ~32'd48); end
    end
    tests++; if (s_req !== 1'b0) begin fails++; $display("FAIL stall_req_drop: got %b want 0", s_req); end
    stall_i = 1'b0;
    step();
    step();
    tests++; if (pop_a.size() != 14) begin fails++; $display("FAIL stall_two_buffered: got %0d pops want 14", pop_a.size()); end
    step();
    step();
    step();
    tests++; if (pop_a.size() < 15 || pop_a[12] !== 32'd48 || pop_a[13] !== 32'd52 || pop_a[14] !== 32'd56) begin fails++; $display("FAIL stall_release_order: got size=%0d want 48,52,56 after 44", pop_a.size()); end
  endtask

  task automatic test_jump();
    do_reset();
    hold = 1'b1;
    step();
    step();
    step();
    tests++; if (s_req !== 1'b0) begin fails++; $display("FAIL jump_credit_full: got req=%b want 0", s_req); end
    jump_i = 1'b1;
    jump_addr_i = 32'h100;
    step();
    tests++; if (s_iv !== 1'b0 || s_req !== 1'b0) begin fails++; $display("FAIL jump_cycle: got v=%b req=%b want 0/0", s_iv, s_req); end
    jump_i = 1'b0;
    hold = 1'b0;
    for (int k = 0; k < 8; k++) step();
    tests++; if (pop_a.size() < 2 || pop_a[0] !== 32'h100 || pop_i[0] !== ~32'h100) begin fails++; $display("FAIL jump_target: got size=%0d want first 100", pop_a.size()); end
    tests++; if (pop_a.size() < 2 || pop_a[1] !== 32'h104) begin fails++; $display("FAIL jump_next: got size=%0d want second 104", pop_a.size()); end
  endtask

  task automatic test_gnt();
    do_reset();
    imem_gnt_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin fails++; $display("FAIL gnt_hold%0d: got req=%b addr=%h want 1/0", k, s_req, s_addr); end
    end
    imem_gnt_i = 1'b1;
    step();
    step();
    tests++; if (s_addr !== 32'h4) begin fails++; $display("FAIL gnt_advance: got %h want 4", s_addr); end
    for (int k = 0; k < 4; k++) step();
    tests++; if (pop_a.size() < 1 || pop_a[0] !== 32'h0 || pop_i[0] !== 32'hFFFF_FFFF) begin fails++; $display("FAIL gnt_first_word: got size=%0d want addr 0", pop_a.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++) step();
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || inst_o !== 32'h7) begin fails++; $display("FAIL midrst_outputs: got req=%b v=%b inst=%h want 0/0/7", imem_req_o, inst_valid_o, inst_o); end
    @(negedge clk);
    rq.delete();
    rq.push_back(32'hDEAD_0000);
    pop_a.delete();
    pop_i.delete();
    rst_n = 1'b1;
    step();
    tests++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin fails++; $display("FAIL midrst_restart: got req=%b addr=%h want 1/0", s_req, s_addr); end
    for (int k = 0; k < 4; k++) step();
    tests++; if (pop_a.size() < 1 || pop_a[0] !== 32'h0 || pop_i[0] !== 32'hFFFF_FFFF) begin fails++; $display("FAIL midrst_stale_ignored: got addr=%h inst=%h want 0/ffffffff", (pop_a.size() > 0) ? pop_a[0] : 32'hx, (pop_i.size() > 0) ? pop_i[0] : 32'hx); end
  endtask

  task automatic test_wrap();
    do_reset();
    jump_i = 1'b1;
    jump_addr_i = 32'hFFFF_FFFC;
    step();
    jump_i = 1'b0;
    step();
    tests++; if (s_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_top: got %h want fffffffc", s_addr); end
    step();
    tests++; if (s_addr !== 32'h0) begin fails++; $display("FAIL wrap_zero: got %h want 0", s_addr); end
    for (int k = 0; k < 5; k++) step();
    tests++; if (pop_a.size() < 2 || pop_a[0] !== 32'hFFFF_FFFC || pop_a[1] !== 32'h0) begin fails++; $display("FAIL wrap_order: got size=%0d want fffffffc,0", pop_a.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    stall_i = 1'b1;
    for (int k = 0; k < 4; k++) step();
    tests++; if (s_iv !== 1'b1 || s_ia !== 32'h0) begin fails++; $display("FAIL b2b_filled: got v=%b addr=%h want 1/0", s_iv, s_ia); end
    jump_i = 1'b1;
    jump_addr_i = 32'h200;
    step();
    tests++; if (s_iv !== 1'b0 || s_ii !== 32'h7) begin fails++; $display("FAIL b2b_jump_nop: got v=%b inst=%h want 0/7", s_iv, s_ii); end
    jump_addr_i = 32'h300;
    step();
    jump_i = 1'b0;
    stall_i = 1'b0;
    for (int k = 0; k < 8; k++) step();
    tests++; if (pop_a.size() < 2 || pop_a[0] !== 32'h300 || pop_a[1] !== 32'h304) begin fails++; $display("FAIL b2b_last_wins: got size=%0d first=%h want 300,304", pop_a.size(), (pop_a.size() > 0) ? pop_a[0] : 32'hx); end
  endtask

  initial begin
    #2;
    test_reset();
    test_stream();
    test_stall();
    test_jump();
    test_gnt();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
